dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder serving the pipeline's memory stage. Accepts one load or store request at a time from the memory stage, holds the pipeline with `stall` for a programmable number of wait states, then returns read data with a one-cycle `resp_valid` pulse. It sits between the memory-stage request signals (MemWriteM, ALUresultM, WriteDataM) and the hazard unit. It replaces the single-cycle RAM with a realistic, latency-bearing responder.

## Interface
- `ADDR_WIDTH`, 8: word-address bits. Depth is 2**ADDR_WIDTH 32-bit words.
- `WAIT_STATES`, 2: extra cycles between acceptance and response. Range 0..15.
- `CLK`  in  1: clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: memory-stage access request (load or store).
- `req_write`  in  1: 1 = store, 0 = load. Sampled with `req_valid`.
- `req_addr`  in  32: byte address (ALUresultM).
- `req_wdata`  in  32: store data (WriteDataM).
- `req_ready`  out  1: request accepted this cycle.
- `resp_valid`  out  1: one-cycle pulse; the response is complete.
- `resp_rdata`  out  32: load data, or echoed store data.
- `stall`  out  1: freeze IF/ID/EX/MEM; to the hazard unit.
- `misalign_err`  out  1: misaligned access flag. Tied 0 unless the macro is defined.

## Operation
- States: IDLE, BUSY, RESP. 4-bit wait counter `cnt`. Request registers: `addr_q`, `wdata_q`, `write_q`.
- IDLE:
  - `req_ready = req_valid`.
  - On `req_valid`, latch addr/wdata/write and load `cnt = WAIT_STATES`.
  - Next state is BUSY if WAIT_STATES > 0, else RESP.
- BUSY:
  - `cnt` decrements each cycle.
  - When `cnt == 1`, the next state is RESP.
- RESP:
  - Store: `mem[addr_q] <= wdata_q`, and `resp_rdata <= wdata_q`.
  - Load: `resp_rdata <= mem[addr_q]`.
  - `resp_valid = 1`, and the next state is IDLE.
- `req_ready` is 0 in BUSY and RESP. A `req_valid` seen during those states is not accepted; it is re-evaluated in the next IDLE cycle.
- `stall = (IDLE & req_valid) | BUSY`. It is combinational and low in RESP, so the pipeline advances in the same cycle `resp_valid`/`resp_rdata` are presented.
- Word index is `addr[ADDR_WIDTH+1:2]`:
  - Higher address bits are ignored, so addresses alias (wrap-around modulo depth).
  - `addr[1:0]` is ignored unless the macro is defined.
- Load-after-store to the same address, in back-to-back transactions, returns the newly stored value.
- Memory array contents are not initialized by reset.

## Timing
- Request accepted at cycle T (IDLE with `req_valid`). RESP occurs at cycle T+1+WAIT_STATES.
- `stall` is high for cycles T..T+WAIT_STATES, i.e. 1+WAIT_STATES cycles, and low in RESP.
- `resp_valid` is registered: high for exactly cycle T+1+WAIT_STATES. `resp_rdata` is valid in that cycle and holds its value until the next RESP.
- Minimum spacing between acceptances is 2+WAIT_STATES cycles. RESP is always followed by an IDLE cycle.
- WAIT_STATES = 0: BUSY is skipped; latency is 1 cycle, and `stall` is high only in the acceptance cycle.
- Reset values: state IDLE, `cnt` 0, `resp_valid` 0, `resp_rdata` 0, `misalign_err` 0, request registers 0.
- `stall` and `req_ready` are forced 0 while `reset` is high.
- Reset in BUSY or RESP aborts the transaction: no response is issued, and a pending store is not written.

## Configuration
- `DMEM_MISALIGN_CHECK_EN` defined:
  - A request with `req_addr[1:0] != 0` is accepted and timed normally.
  - In RESP: the store is suppressed, `resp_rdata = 0`, and `misalign_err = 1` for that one cycle alongside `resp_valid`.
  - `misalign_err` is registered and resets to 0.
- Not defined: `req_addr[1:0]` is ignored, and `misalign_err` is constant 0.

## Test plan
- Store then load, WAIT_STATES=2:
  - Store 0xDEADBEEF to 0x10, then load 0x10.
  - Required: each transaction shows stall high for 3 cycles; `resp_valid` at T+3; the load returns 0xDEADBEEF.
- WAIT_STATES=0, back-to-back loads of 0x0 and 0x4 with `req_valid` held:
  - Required: stall 1 cycle each; responses at T+1 and T+3.
  - Required: `req_ready` is low in the RESP cycle.
- Wrap-around, ADDR_WIDTH=8:
  - Store 0x12345678 to 0x400, then load 0x0.
  - Required: the load returns 0x12345678.
- Reset mid-transaction:
  - Store 0xAAAA5555 to 0x20 (previously holding 0x1), with reset asserted in the first BUSY cycle.
  - Required: no `resp_valid`, stall drops to 0, and a subsequent load of 0x20 returns 0x1.
- Macro on:
  - Store 0xFFFFFFFF to 0x22.
  - Required: `misalign_err=1` with `resp_valid`, and `resp_rdata=0`; a load of 0x20 returns its prior value.
- Macro off, same stimulus:
  - Required: `misalign_err=0`, and a load of 0x20 returns 0xFFFFFFFF.
- Request during BUSY:
  - Toggle `req_valid` with a different address mid-BUSY.
  - Required: latched `addr_q` is unchanged, and the response carries the original address's data.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one load/store at a time, WAIT_STATES of stall, then a one-cycle response.
// Define DMEM_MISALIGN_CHECK_EN to flag (and suppress) accesses with a non-zero byte offset.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        stall,
    output logic        misalign_err
);

    localparam int         DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH+1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  write_q, write_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [31:0]           resp_rdata_q, resp_rdata_d;
    logic [31:0]           mem [DEPTH];

    logic                  enter_resp;
    logic                  bad_align;
    logic                  held_bad_align;
    logic                  do_store;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  unused_addr;

    // Upper address bits only alias; byte offset matters only with the check enabled.
    assign unused_addr = ^{req_addr[31:ADDR_WIDTH+2], addr_d[1:0]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        req_ready = 1'b0;
        stall     = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = req_valid;
                stall     = req_valid;
                if (req_valid) begin
                    addr_d  = req_addr[ADDR_WIDTH+1:0];
                    wdata_d = req_wdata;
                    write_d = req_write;
                    cnt_d   = WS_INIT;
                    state_d = (WAIT_STATES > 0) ? BUSY : RESP;
                end
            end
            BUSY: begin
                stall = 1'b1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (reset) begin
            req_ready = 1'b0;
            stall     = 1'b0;
        end
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    assign bad_align      = |addr_d[1:0];
    assign held_bad_align = |addr_q[1:0];
    assign misalign_d     = enter_resp & bad_align;
    assign misalign_err   = misalign_q;

    always_ff @(posedge CLK) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`else
    assign bad_align      = 1'b0;
    assign held_bad_align = 1'b0;
    assign misalign_err   = 1'b0;
`endif

    // Response data is captured on the edge entering RESP so it is presented during RESP.
    // addr_d/wdata_d/write_d cover both the direct IDLE->RESP path and the BUSY->RESP path.
    assign enter_resp = (state_d == RESP);
    assign rd_idx     = addr_d[ADDR_WIDTH+1:2];

    always_comb begin
        resp_valid_d = enter_resp;
        resp_rdata_d = resp_rdata_q;
        if (enter_resp) begin
            if (bad_align) begin
                resp_rdata_d = 32'd0;
            end else if (write_d) begin
                resp_rdata_d = wdata_d;
            end else begin
                resp_rdata_d = mem[rd_idx];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            addr_q       <= '0;
            wdata_q      <= 32'd0;
            write_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // The store commits at the end of RESP; a reset in that cycle drops it.
    assign do_store = (state_q == RESP) && write_q && !held_bad_align && !reset;

    always_ff @(posedge CLK) begin
        if (do_store) begin
            mem[addr_q[ADDR_WIDTH+1:2]] <= wdata_q;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_STATES=2 instance and a WAIT_STATES=0 instance.
module tb_dmem_responder;

    localparam int WS = 2;

    logic        CLK = 1'b0;
    logic        reset;
    logic        req_valid, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, stall, misalign_err;
    logic [31:0] resp_rdata;

    logic        z_req_valid, z_req_write;
    logic [31:0] z_req_addr, z_req_wdata;
    logic        z_req_ready, z_resp_valid, z_stall, z_misalign_err;
    logic [31:0] z_resp_rdata;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_merr;
    } vec_t;

    vec_t vecs[8];
    vec_t zvecs[4];

    always #5 CLK = ~CLK;

    dmem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(WS)) dut (
        .CLK(CLK), .reset(reset),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .stall(stall),
        .misalign_err(misalign_err)
    );

    dmem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut0 (
        .CLK(CLK), .reset(reset),
        .req_valid(z_req_valid), .req_write(z_req_write),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .req_ready(z_req_ready), .resp_valid(z_resp_valid),
        .resp_rdata(z_resp_rdata), .stall(z_stall),
        .misalign_err(z_misalign_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One transaction on the WAIT_STATES=2 instance, measuring latency and stall length.
    task automatic run_txn(input string tag, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_me);
        int          lat;
        int          stalls;
        bit          got;
        logic [31:0] exp;
        @(negedge CLK);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        exp_q.push_back(exp_rd);
        #1;
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        stalls = stall ? 1 : 0;
        lat    = 0;
        got    = 0;
        while (!got && lat < 20) begin
            @(negedge CLK);
            req_valid = 1'b0;
            #1;
            lat++;
            if (resp_valid) got = 1;
            else if (stall) stalls++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(WS + 1));
        check({tag, "_stall_cycles"}, 32'(stalls), 32'(WS + 1));
        exp = exp_q.pop_front();
        if (got) begin
            check({tag, "_rdata"}, resp_rdata, exp);
            check({tag, "_merr"}, 32'(misalign_err), 32'(exp_me));
            check({tag, "_stall_in_resp"}, 32'(stall), 32'd0);
        end
        @(negedge CLK);
        #1;
        check({tag, "_pulse_end"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          seen_resp;
        int          seen_stall;
        logic [31:0] mis_rd;
        logic        mis_me;
        logic [31:0] after_mis;

        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0400, 32'h1234_5678, 32'h1234_5678, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h1234_5678, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
        vecs[5] = '{1'b0, 32'h0000_03FC, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
        vecs[6] = '{1'b0, 32'h0000_07FC, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
        vecs[7] = '{1'b1, 32'h0000_0020, 32'h0000_0001, 32'h0000_0001, 1'b0};

        zvecs[0] = '{1'b1, 32'h0000_0000, 32'h0A0A_0A0A, 32'h0A0A_0A0A, 1'b0};
        zvecs[1] = '{1'b1, 32'h0000_0004, 32'h0B0B_0B0B, 32'h0B0B_0B0B, 1'b0};
        zvecs[2] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0A0A_0A0A, 1'b0};
        zvecs[3] = '{1'b0, 32'h0000_0004, 32'h0000_0000, 32'h0B0B_0B0B, 1'b0};

`ifdef DMEM_MISALIGN_CHECK_EN
        mis_rd    = 32'h0000_0000;
        mis_me    = 1'b1;
        after_mis = 32'h0000_0001;
`else
        mis_rd    = 32'hFFFF_FFFF;
        mis_me    = 1'b0;
        after_mis = 32'hFFFF_FFFF;
`endif

        // Reset with requests pending: outputs at reset values, handshakes forced low.
        reset       = 1'b1;
        req_valid   = 1'b1;
        req_write   = 1'b0;
        req_addr    = 32'd0;
        req_wdata   = 32'd0;
        z_req_valid = 1'b1;
        z_req_write = 1'b0;
        z_req_addr  = 32'd0;
        z_req_wdata = 32'd0;
        repeat (2) @(negedge CLK);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_merr", 32'(misalign_err), 32'd0);
        check("rst_z_req_ready", 32'(z_req_ready), 32'd0);
        check("rst_z_stall", 32'(z_stall), 32'd0);
        check("rst_z_resp_rdata", z_resp_rdata, 32'd0);
        req_valid   = 1'b0;
        z_req_valid = 1'b0;
        @(negedge CLK);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].write, vecs[i].addr, vecs[i].wdata,
                    vecs[i].exp_rdata, vecs[i].exp_merr);
        end

        // Reset in the first BUSY cycle of a store aborts it.
        @(negedge CLK);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_0020;
        req_wdata = 32'hAAAA_5555;
        #1;
        check("abort_accept_stall", 32'(stall), 32'd1);
        @(negedge CLK);
        req_valid = 1'b0;
        reset     = 1'b1;
        #1;
        check("abort_stall_forced", 32'(stall), 32'd0);
        @(negedge CLK);
        reset      = 1'b0;
        seen_resp  = 0;
        seen_stall = 0;
        repeat (6) begin
            #1;
            if (resp_valid) seen_resp = 1;
            if (stall) seen_stall = 1;
            @(negedge CLK);
        end
        check("abort_no_resp", 32'(seen_resp), 32'd0);
        check("abort_no_stall", 32'(seen_stall), 32'd0);
        run_txn("abort_reload", 1'b0, 32'h0000_0020, 32'd0, 32'h0000_0001, 1'b0);

        // Misaligned store to 0x22, then reload the word at 0x20.
        run_txn("mis_store", 1'b1, 32'h0000_0022, 32'hFFFF_FFFF, mis_rd, mis_me);
        run_txn("mis_reload", 1'b0, 32'h0000_0020, 32'd0, after_mis, 1'b0);

        // A different request arriving mid-BUSY is ignored.
        run_txn("busy_pre0", 1'b1, 32'h0000_0040, 32'h55AA_0011, 32'h55AA_0011, 1'b0);
        run_txn("busy_pre1", 1'b1, 32'h0000_0044, 32'h9988_7766, 32'h9988_7766, 1'b0);
        @(negedge CLK);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0040;
        #1;
        check("busy_accept_ready", 32'(req_ready), 32'd1);
        @(negedge CLK);
        req_addr = 32'h0000_0044;
        #1;
        check("busy_ignored_ready", 32'(req_ready), 32'd0);
        check("busy_ignored_stall", 32'(stall), 32'd1);
        @(negedge CLK);
        req_valid = 1'b0;
        #1;
        check("busy_no_early_resp", 32'(resp_valid), 32'd0);
        @(negedge CLK);
        #1;
        check("busy_resp_valid", 32'(resp_valid), 32'd1);
        check("busy_resp_rdata", resp_rdata, 32'h55AA_0011);
        @(negedge CLK);
        #1;
        check("busy_pulse_end", 32'(resp_valid), 32'd0);

        // WAIT_STATES=0 with req_valid held throughout: accept, RESP, accept, RESP, ...
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            z_req_valid = 1'b1;
            z_req_write = zvecs[i].write;
            z_req_addr  = zvecs[i].addr;
            z_req_wdata = zvecs[i].wdata;
            #1;
            check($sformatf("ws0_%0d_ready", i), 32'(z_req_ready), 32'd1);
            check($sformatf("ws0_%0d_stall", i), 32'(z_stall), 32'd1);
            check($sformatf("ws0_%0d_no_resp", i), 32'(z_resp_valid), 32'd0);
            @(negedge CLK);
            #1;
            check($sformatf("ws0_%0d_resp_valid", i), 32'(z_resp_valid), 32'd1);
            check($sformatf("ws0_%0d_rdata", i), z_resp_rdata, zvecs[i].exp_rdata);
            check($sformatf("ws0_%0d_ready_in_resp", i), 32'(z_req_ready), 32'd0);
            check($sformatf("ws0_%0d_stall_in_resp", i), 32'(z_stall), 32'd0);
            check($sformatf("ws0_%0d_merr", i), 32'(z_misalign_err), 32'd0);
        end
        @(negedge CLK);
        z_req_valid = 1'b0;
        #1;
        check("ws0_pulse_end", 32'(z_resp_valid), 32'd0);
        check("ws0_idle_stall", 32'(z_stall), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
